// File: rtl/caravel_clk_pkg.sv
// Shared definitions for the caravel clock divider bank.
//  - ch_state_e : per-channel run state (IDLE / RUN / DRAIN)
//  - cnt_w()    : width of a channel's cycle counter for a given divide-select width
//  - ratio()    : divide ratio for a divide select (sel + 2)
package caravel_clk_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_RUN   = 2'd1,
    CH_DRAIN = 2'd2
  } ch_state_e;

  // The counter must hold ratio-1 = 2^div_w, which needs div_w+1 bits.
  function automatic int cnt_w(input int div_w);
    return div_w + 1;
  endfunction

  function automatic int ratio(input int sel);
    return sel + 2;
  endfunction

endpackage

// File: rtl/caravel_clkdiv_channel.sv
// One glitch-free divider channel: run FSM, period counter, applied divide
// select, staged reset and (optionally) a rise-event counter.
// Optional feature macro: CLKDIV_CYCLE_CNT_EN adds the cyc_cnt output.
// Ports:
//  clk, rst_n      : pll clock, async active-low reset
//  ext_reset       : sync active-high soft reset for resetb_sync / cyc_cnt
//  ch_en, div_sel  : run enable and requested divide select
//  clk_out         : divided clock (registered)
//  clk_rise        : high in the cycle clk_out rises
//  resetb_sync     : staged active-low channel reset
//  div_active      : divide select applied to the current period
//  state_dbg       : current FSM state
//  cyc_cnt         : rise-event count (CLKDIV_CYCLE_CNT_EN only)
module caravel_clkdiv_channel
  import caravel_clk_pkg::*;
#(
  parameter int DIV_W      = 3,
  parameter int RST_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_reset,
  input  logic             ch_en,
  input  logic [DIV_W-1:0] div_sel,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             resetb_sync,
  output logic [DIV_W-1:0] div_active,
  output logic [1:0]       state_dbg
`ifdef CLKDIV_CYCLE_CNT_EN
  ,
  output logic [15:0]      cyc_cnt
`endif
);

  localparam int CNT_W = cnt_w(DIV_W);
  localparam int STG_W = $clog2(RST_STAGES + 1);
  localparam logic [STG_W-1:0] STG_MAX = STG_W'(RST_STAGES);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_rise_q, clk_rise_d;
  logic             resetb_sync_q, resetb_sync_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] ratio_cur, ratio_nxt;
  logic             wrap, running_d, enter_idle;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    ratio_cur    = CNT_W'(ratio(int'(div_active_q)));
    wrap         = (cnt_q == ratio_cur - CNT_W'(1));

    case (state_q)
      CH_IDLE: begin
        if (ch_en) begin
          state_d      = CH_RUN;
          cnt_d        = '0;
          div_active_d = div_sel;
        end
      end
      default: begin
        // RUN and DRAIN count identically; they differ only in what the
        // wrap edge does, so a re-raised enable in DRAIN causes no gap.
        if (wrap) begin
          cnt_d = '0;
          if (ch_en) begin
            state_d      = CH_RUN;
            div_active_d = div_sel;
          end else begin
            state_d = CH_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ch_en ? CH_RUN : CH_DRAIN;
        end
      end
    endcase

    // Outputs are decoded from the next counter value so they are registered.
    ratio_nxt  = CNT_W'(ratio(int'(div_active_d)));
    running_d  = (state_d != CH_IDLE);
    clk_out_d  = running_d && (cnt_d < (ratio_nxt >> 1));
    clk_rise_d = running_d && (cnt_d == '0);
    enter_idle = (state_q != CH_IDLE) && !running_d;

    // A rise coinciding with ext_reset is dropped: the clear wins.
    stage_d = stage_q;
    if (ext_reset || enter_idle) begin
      stage_d = '0;
    end else if (clk_rise_q && (stage_q != STG_MAX)) begin
      stage_d = stage_q + STG_W'(1);
    end
    resetb_sync_d = (stage_d == STG_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CH_IDLE;
      cnt_q         <= '0;
      div_active_q  <= '0;
      clk_out_q     <= 1'b0;
      clk_rise_q    <= 1'b0;
      resetb_sync_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_active_q  <= div_active_d;
      clk_out_q     <= clk_out_d;
      clk_rise_q    <= clk_rise_d;
      resetb_sync_q <= resetb_sync_d;
      stage_q       <= stage_d;
    end
  end

`ifdef CLKDIV_CYCLE_CNT_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (ext_reset || enter_idle) begin
      cyc_cnt_d = '0;
    end else if (clk_rise_q) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;  // wraps naturally at 16'hFFFF
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

  assign clk_out     = clk_out_q;
  assign clk_rise    = clk_rise_q;
  assign resetb_sync = resetb_sync_q;
  assign div_active  = div_active_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/caravel_clock_div_bank.sv
// NUM_CH-channel programmable clock divider bank, fully synchronous to pll_clk.
// Optional feature macro: CLKDIV_CYCLE_CNT_EN adds cyc_cnt (16 bits per channel).
// Ports:
//  pll_clk, resetb  : sole clock, async active-low master reset
//  ext_reset        : sync active-high soft reset of the staged resets
//  ch_en            : per-channel run enable
//  div_sel          : requested divide select, channel i at [i*DIV_W +: DIV_W]
//  clk_out          : divided clocks
//  clk_rise         : per-channel rise strobes
//  resetb_sync      : per-channel staged active-low resets
//  div_active       : divide select currently applied, same packing as div_sel
//  ch_state_dbg     : per-channel FSM state, channel i at [2*i +: 2]
//  cyc_cnt          : per-channel rise counts (CLKDIV_CYCLE_CNT_EN only)
module caravel_clock_div_bank
  import caravel_clk_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 3,
  parameter int RST_STAGES = 3
) (
  input  logic                    pll_clk,
  input  logic                    resetb,
  input  logic                    ext_reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_sel,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_rise,
  output logic [NUM_CH-1:0]       resetb_sync,
  output logic [NUM_CH*DIV_W-1:0] div_active,
  output logic [NUM_CH*$bits(ch_state_e)-1:0] ch_state_dbg
`ifdef CLKDIV_CYCLE_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]    cyc_cnt
`endif
);

  localparam int ST_W = $bits(ch_state_e);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    caravel_clkdiv_channel #(
      .DIV_W      (DIV_W),
      .RST_STAGES (RST_STAGES)
    ) u_ch (
      .clk         (pll_clk),
      .rst_n       (resetb),
      .ext_reset   (ext_reset),
      .ch_en       (ch_en[i]),
      .div_sel     (div_sel[i*DIV_W +: DIV_W]),
      .clk_out     (clk_out[i]),
      .clk_rise    (clk_rise[i]),
      .resetb_sync (resetb_sync[i]),
      .div_active  (div_active[i*DIV_W +: DIV_W]),
      .state_dbg   (ch_state_dbg[i*ST_W +: ST_W])
`ifdef CLKDIV_CYCLE_CNT_EN
      ,
      .cyc_cnt     (cyc_cnt[i*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_caravel_clock_div_bank.sv
// Self-checking bench for caravel_clock_div_bank (NUM_CH=2, DIV_W=3, RST_STAGES=3).
// The reference model works per period: when a period starts it queues the whole
// high/low pattern for that period, and a new period (or idle) is decided only
// when that pattern is used up. Expected output vectors go into exp_q at each
// posedge; a monitor pops and compares them at each negedge.
// Handshake: every pll_clk cycle is one output beat; the monitor consumes one
// expected vector per negedge whenever one is queued.
module tb_caravel_clock_div_bank;

  localparam int NUM_CH     = 2;
  localparam int DIV_W      = 3;
  localparam int RST_STAGES = 3;
  localparam int LANE_W     = DIV_W + 3;
  localparam int VEC_W      = NUM_CH * LANE_W;

  logic                    pll_clk = 1'b0;
  logic                    resetb;
  logic                    ext_reset;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] div_sel;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_rise;
  logic [NUM_CH-1:0]       resetb_sync;
  logic [NUM_CH*DIV_W-1:0] div_active;
  logic [NUM_CH*2-1:0]     ch_state_dbg;
`ifdef CLKDIV_CYCLE_CNT_EN
  logic [NUM_CH*16-1:0]    cyc_cnt;
  logic [NUM_CH*16-1:0]    exp_cyc_q[$];
`endif

  // ---------------- clock / reset ----------------
  always #5 pll_clk = ~pll_clk;

  caravel_clock_div_bank #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .RST_STAGES (RST_STAGES)
  ) dut (
    .pll_clk      (pll_clk),
    .resetb       (resetb),
    .ext_reset    (ext_reset),
    .ch_en        (ch_en),
    .div_sel      (div_sel),
    .clk_out      (clk_out),
    .clk_rise     (clk_rise),
    .resetb_sync  (resetb_sync),
    .div_active   (div_active),
    .ch_state_dbg (ch_state_dbg)
`ifdef CLKDIV_CYCLE_CNT_EN
    ,
    .cyc_cnt      (cyc_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [VEC_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model state ----------------
  logic [1:0] wave_q [NUM_CH][$];  // per remaining cycle of the period: {first_cycle, high}
  bit         in_period[NUM_CH];
  int         act_sel[NUM_CH];
  int         stages[NUM_CH];
  int         rises[NUM_CH];
  bit         exp_clk[NUM_CH];
  bit         exp_rise[NUM_CH];

  task automatic model_edge();
    logic [VEC_W-1:0]         v;
    logic [NUM_CH*16-1:0]     cv;
    for (int c = 0; c < NUM_CH; c++) begin
      bit         was_in      = in_period[c];
      bit         rise_before = exp_rise[c];
      logic [1:0] e;
      if (!resetb) begin
        wave_q[c].delete();
        in_period[c] = 1'b0;
        act_sel[c]   = 0;
        stages[c]    = 0;
        rises[c]     = 0;
        exp_clk[c]   = 1'b0;
        exp_rise[c]  = 1'b0;
      end else begin
        if (wave_q[c].size() == 0) begin
          if (ch_en[c]) begin
            int r;
            act_sel[c] = int'(div_sel[c*DIV_W +: DIV_W]);
            r = act_sel[c] + 2;
            for (int k = 0; k < r; k++) wave_q[c].push_back({k == 0, k < r / 2});
            in_period[c] = 1'b1;
          end else begin
            in_period[c] = 1'b0;
          end
        end
        if (in_period[c]) begin
          e = wave_q[c].pop_front();
          exp_clk[c]  = e[0];
          exp_rise[c] = e[1];
        end else begin
          exp_clk[c]  = 1'b0;
          exp_rise[c] = 1'b0;
        end
        if (ext_reset || (was_in && !in_period[c])) begin
          stages[c] = 0;
          rises[c]  = 0;
        end else if (rise_before) begin
          if (stages[c] < RST_STAGES) stages[c]++;
          rises[c] = (rises[c] + 1) % 65536;
        end
      end
      v[c*LANE_W +: LANE_W] = {DIV_W'(act_sel[c]), stages[c] >= RST_STAGES, exp_rise[c], exp_clk[c]};
      cv[c*16 +: 16] = 16'(rises[c]);
    end
    exp_q.push_back(v);
`ifdef CLKDIV_CYCLE_CNT_EN
    exp_cyc_q.push_back(cv);
`endif
  endtask

  function automatic logic [VEC_W-1:0] pack_dut();
    logic [VEC_W-1:0] v;
    for (int c = 0; c < NUM_CH; c++)
      v[c*LANE_W +: LANE_W] = {div_active[c*DIV_W +: DIV_W], resetb_sync[c], clk_rise[c], clk_out[c]};
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge pll_clk);
      if (exp_q.size() != 0) begin
        logic [VEC_W-1:0] exp_v;
        logic [VEC_W-1:0] got_v;
        exp_v = exp_q.pop_front();
        got_v = pack_dut();
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL outputs t=%0t got=%h exp=%h ({div_active,resetb_sync,clk_rise,clk_out} per ch)",
                   $time, got_v, exp_v);
        end
      end
`ifdef CLKDIV_CYCLE_CNT_EN
      if (exp_cyc_q.size() != 0) begin
        logic [NUM_CH*16-1:0] exp_c;
        exp_c = exp_cyc_q.pop_front();
        checks++;
        if (cyc_cnt !== exp_c) begin
          failures++;
          $display("FAIL cyc_cnt t=%0t got=%h exp=%h", $time, cyc_cnt, exp_c);
        end
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pll_clk);
    model_edge();
    #1;
  endtask

  task automatic wait_rise(input int c);
    int n = 0;
    while (!exp_rise[c] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!exp_rise[c]) begin
      failures++;
      $display("FAIL wait_rise ch=%0d got=no_rise exp=rise within 40 cycles", c);
    end
  endtask

  task automatic set_sel(input int c, input int s);
    div_sel[c*DIV_W +: DIV_W] = DIV_W'(s);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({clk_out, clk_rise, resetb_sync, div_active} !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", name, {clk_out, clk_rise, resetb_sync, div_active});
    end
  endtask

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetb    = 1'b0;
    ext_reset = 1'b0;
    ch_en     = '0;
    div_sel   = '0;
    repeat (3) tick();
    check_zero("reset_state");
    resetb = 1'b1;
    repeat (2) tick();

    // ch0 divide by 2, ch1 divide by 5; startup covers staged-reset release
    set_sel(0, 0);
    set_sel(1, 3);
    ch_en = 2'b11;
    repeat (20) tick();

    // change ch1 request to 6 one cycle into a period
    wait_rise(1);
    tick();
    set_sel(1, 6);
    repeat (24) tick();

    // drop ch1 enable at cnt=0 with R=5, let it drain to idle
    set_sel(1, 3);
    repeat (10) tick();
    wait_rise(1);
    ch_en[1] = 1'b0;
    repeat (12) tick();
    // re-raise during drain
    ch_en[1] = 1'b1;
    wait_rise(1);
    ch_en[1] = 1'b0;
    repeat (2) tick();
    ch_en[1] = 1'b1;
    repeat (20) tick();

    // ext_reset pulse, then ext_reset coinciding with a rise
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    repeat (30) tick();
    wait_rise(0);
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    repeat (20) tick();

    // async reset during ch0 high phase (R=7, high for 3 cycles)
    set_sel(0, 5);
    repeat (10) tick();
    wait_rise(0);
    tick();
    @(negedge pll_clk);
    #1;
    resetb = 1'b0;
    #1;
    check_zero("async_reset_mid_high");
    repeat (3) tick();
    resetb = 1'b1;
    repeat (5) tick();

    // randomized traffic
    ch_en = 2'b11;
    repeat (1500) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 11) == 0) ch_en[c] = ~ch_en[c];
        if ($urandom_range(0, 5) == 0) set_sel(c, int'($urandom_range(0, 7)));
      end
      ext_reset = ($urandom_range(0, 39) == 0);
      tick();
    end
    ext_reset = 1'b0;

    // steady run: ten periods on ch0 at R=3
    set_sel(0, 1);
    ch_en = 2'b11;
    repeat (12) tick();
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    repeat (30) tick();

    ch_en = '0;
    repeat (25) tick();
    repeat (2) @(negedge pll_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending expected vectors", exp_q.size());
    end
    report();
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    report();
    $finish;
  end

endmodule
